// File: rtl/addn_pkg.sv
// Shared helpers and types for the pipelined N-operand adder.
package addn_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sum_w(input int w, input int n);
        return w + clog2_min1(n);
    endfunction

    // Operand count remaining after lvl pairwise-reduction levels.
    function automatic int cnt_at(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    typedef struct packed {
        logic mode;
        logic last;
        logic vld;
    } beat_tag_t;

endpackage

// File: rtl/addn_tree_stage.sv
// One registered level of the adder tree: sums adjacent pairs, an odd leftover passes through.
module addn_tree_stage
    import addn_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int W_IN   = 8,
    parameter int SIGNED = 0,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int W_OUT = W_IN + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  beat_tag_t              tag_in,
    input  logic [N_IN*W_IN-1:0]   d,
    output beat_tag_t              tag_out,
    output logic [N_OUT*W_OUT-1:0] q
);

    logic [N_OUT*W_OUT-1:0] sum_c;
    logic                   vld_q;
    logic                   mode_q;
    logic                   last_q;

    function automatic logic [W_OUT-1:0] ext1(input logic [W_IN-1:0] a);
        if (SIGNED != 0) return {a[W_IN-1], a};
        return {1'b0, a};
    endfunction

    for (genvar k = 0; k < N_OUT; k++) begin : g_pair
        if (2 * k + 1 < N_IN) begin : g_add
            assign sum_c[k*W_OUT +: W_OUT] = ext1(d[(2*k)*W_IN +: W_IN])
                                           + ext1(d[(2*k+1)*W_IN +: W_IN]);
        end else begin : g_pass
            assign sum_c[k*W_OUT +: W_OUT] = ext1(d[(2*k)*W_IN +: W_IN]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= tag_in.vld;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_q <= tag_in.mode;
            last_q <= tag_in.last;
            q      <= sum_c;
        end
    end

    assign tag_out = '{mode: mode_q, last: last_q, vld: vld_q};

endmodule

// File: rtl/addn_pipe_acc.sv
// Pipelined N-operand adder tree with an optional burst accumulator and valid/ready handshake.
module addn_pipe_acc
    import addn_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_IN   = 3,
    parameter int SIGNED   = 0,
    parameter int ACC_XTRA = 8,
    localparam int L       = clog2_min1(NUM_IN),
    localparam int SW      = sum_w(WIDTH, NUM_IN),
    localparam int ACC_W   = SW + ACC_XTRA
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_mode,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic                    out_ovf
);

    localparam int BUS_W = NUM_IN * SW;

    logic                   en;
    logic [L:0][BUS_W-1:0]  data_p;
    beat_tag_t              tag_p [0:L];
    logic [SW-1:0]          tree_sum;
    logic [ACC_W-1:0]       sum_ext;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W:0]         add_full;
    logic                   ovf_now;
    logic                   ovf_st;

    function automatic logic [ACC_W-1:0] ext_acc(input logic [SW-1:0] s);
        if (SIGNED != 0) return ACC_W'($signed(s));
        return ACC_W'(s);
    endfunction

    function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] b,
                                     input logic [ACC_W:0]   s);
        if (SIGNED != 0) return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        return s[ACC_W];
    endfunction

    // A held output freezes the whole pipe, bubbles included.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign data_p[0] = {{(NUM_IN*(SW-WIDTH)){1'b0}}, in_data};
    assign tag_p[0]  = '{mode: in_mode, last: in_last, vld: in_valid};

    // Tree levels p0 -> pL: each level narrows the operand count and widens by one bit
    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int N_I = cnt_at(NUM_IN, i);
        localparam int W_I = WIDTH + i;
        localparam int N_O = (N_I + 1) / 2;
        localparam int W_O = W_I + 1;

        logic [N_O*W_O-1:0] q_i;

        addn_tree_stage #(
            .N_IN  (N_I),
            .W_IN  (W_I),
            .SIGNED(SIGNED)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .tag_in (tag_p[i]),
            .d      (data_p[i][N_I*W_I-1:0]),
            .tag_out(tag_p[i+1]),
            .q      (q_i)
        );

        if (N_O * W_O < BUS_W) begin : g_pad
            assign data_p[i+1] = {{(BUS_W - N_O*W_O){1'b0}}, q_i};
        end else begin : g_full
            assign data_p[i+1] = q_i;
        end
    end

    assign tree_sum = data_p[L][SW-1:0];

    always_comb begin
        sum_ext  = ext_acc(tree_sum);
        add_full = {1'b0, acc} + {1'b0, sum_ext};
        ovf_now  = add_ovf(acc, sum_ext, add_full);
    end

    // Accumulate / output stage pL -> out
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            ovf_st    <= 1'b0;
        end else if (en) begin
            out_valid <= tag_p[L].vld && (!tag_p[L].mode || tag_p[L].last);
            if (tag_p[L].vld) begin
                if (!tag_p[L].mode) begin
                    out_sum <= sum_ext;
                    out_ovf <= 1'b0;
                end else if (!tag_p[L].last) begin
                    acc    <= add_full[ACC_W-1:0];
                    ovf_st <= ovf_st || ovf_now;
                end else begin
                    out_sum <= add_full[ACC_W-1:0];
                    out_ovf <= ovf_st || ovf_now;
                    acc     <= '0;
                    ovf_st  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_addn_pipe_acc.sv
// Bench for addn_pipe_acc: directed table and bursts on three configurations, then randomized traffic vs a reference model.
module tb_addn_pipe_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_data;
    logic        in_mode;
    logic        in_last;
    logic        out_ready;

    logic        rdy_m, rdy_s, rdy_x;
    logic        ov_m, ov_s, ov_x;
    logic [17:0] sum_m, sum_s;
    logic [9:0]  sum_x;
    logic        ovf_m, ovf_s, ovf_x;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    addn_pipe_acc #(.WIDTH(8), .NUM_IN(3), .SIGNED(0), .ACC_XTRA(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last), .out_valid(ov_m), .out_ready(out_ready),
        .out_sum(sum_m), .out_ovf(ovf_m));

    addn_pipe_acc #(.WIDTH(8), .NUM_IN(3), .SIGNED(1), .ACC_XTRA(8)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_ovf(ovf_s));

    addn_pipe_acc #(.WIDTH(8), .NUM_IN(3), .SIGNED(0), .ACC_XTRA(0)) u_x0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_x), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last), .out_valid(ov_x), .out_ready(out_ready),
        .out_sum(sum_x), .out_ovf(ovf_x));

    function automatic longint get_sum(int k);
        case (k)
            0:       return longint'(sum_m);
            1:       return longint'($signed(sum_s));
            default: return longint'(sum_x);
        endcase
    endfunction

    function automatic logic get_ovf(int k);
        return (k == 0) ? ovf_m : (k == 1) ? ovf_s : ovf_x;
    endfunction

    function automatic logic get_vld(int k);
        return (k == 0) ? ov_m : (k == 1) ? ov_s : ov_x;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive(int a, int b, int c, bit m, bit l);
        in_data  = {8'(c), 8'(b), 8'(a)};
        in_mode  = m;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    int      cnt [3];
    longint  lsum [3];
    logic    lovf [3];
    longint  q_m [$];

    task automatic collect(int ncyc);
        q_m.delete();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; lsum[k] = -999; lovf[k] = 1'bx;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (get_vld(k)) begin
                    cnt[k]++;
                    lsum[k] = get_sum(k);
                    lovf[k] = get_ovf(k);
                    if (k == 0) q_m.push_back(get_sum(0));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Reference model: mathematical sums, wrapped into each instance's accumulator width.
    typedef struct {
        longint s [3];
        bit     o [3];
    } exp_t;

    exp_t   exp_q [$];
    longint m_acc [3];
    bit     m_ovf [3];
    int     aw_of [3] = '{18, 18, 10};
    bit     sg_of [3] = '{1'b0, 1'b1, 1'b0};

    function automatic longint wrapv(longint v, int aw, bit sg);
        longint md, r;
        md = longint'(1) << aw;
        r  = ((v % md) + md) % md;
        if (sg && r >= md / 2) r = r - md;
        return r;
    endfunction

    function automatic bit out_of_range(longint v, int aw, bit sg);
        longint md;
        md = longint'(1) << aw;
        if (sg) return (v < -(md / 2)) || (v >= md / 2);
        return v >= md;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_accept(logic [23:0] d, bit m, bit l);
        exp_t   rec;
        longint s, tot;
        logic [7:0] b;
        bit     o;
        for (int k = 0; k < 3; k++) begin
            s = 0;
            for (int j = 0; j < 3; j++) begin
                b = d[j*8 +: 8];
                s += sg_of[k] ? longint'($signed(b)) : longint'(b);
            end
            if (!m) begin
                rec.s[k] = s; rec.o[k] = 1'b0;
            end else begin
                tot = m_acc[k] + s;
                o   = out_of_range(tot, aw_of[k], sg_of[k]);
                tot = wrapv(tot, aw_of[k], sg_of[k]);
                if (!l) begin
                    m_acc[k] = tot; m_ovf[k] = m_ovf[k] | o;
                end else begin
                    rec.s[k] = tot; rec.o[k] = m_ovf[k] | o;
                    m_acc[k] = 0;   m_ovf[k] = 1'b0;
                end
            end
        end
        if (!m || l) exp_q.push_back(rec);
    endtask

    bit     held_prev = 1'b0;
    longint prev_sum;
    logic   prev_ovf;
    int     n_stall = 0;

    task automatic step(bit iv, logic [23:0] d, bit m, bit l, bit ordy);
        bit   acc_b, fire;
        exp_t rec;
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        in_last   = l;
        out_ready = ordy;
        #1;
        chk("in_ready_rule", rdy_m, (!ov_m || ordy));
        if (!rdy_m) n_stall++;
        if (held_prev) begin
            chk("hold_valid", ov_m, 1);
            chk("hold_sum", get_sum(0), prev_sum);
            chk("hold_ovf", ovf_m, prev_ovf);
        end
        acc_b = iv && rdy_m;
        fire  = ov_m && ordy;
        if (fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                rec = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("rand_sum[%0d]", k), get_sum(k), rec.s[k]);
                    chk($sformatf("rand_ovf[%0d]", k), get_ovf(k), rec.o[k]);
                end
            end
        end
        held_prev = ov_m && !ordy;
        prev_sum  = get_sum(0);
        prev_ovf  = ovf_m;
        @(posedge clk); #1;
        if (acc_b) model_accept(d, m, l);
    endtask

    typedef struct {
        int     a, b, c;
        longint exp_u;
        longint exp_s;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;

        tbl[0] = '{10, 20, 30, 60, 60};
        tbl[1] = '{255, 255, 255, 765, -3};
        tbl[2] = '{128, 128, 127, 383, -129};
        tbl[3] = '{0, 0, 0, 0, 0};
        tbl[4] = '{1, 254, 100, 355, 99};

        do_reset();
        chk("reset_out_valid", ov_m, 0);
        chk("reset_out_sum", sum_m, 0);
        chk("reset_out_ovf", ovf_m, 0);
        chk("reset_in_ready", rdy_m, 1);

        // Single mode-0 beats: latency, unsigned and signed sums
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, 1'b0);
            lat = 1;
            while (!ov_m && lat < 12) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("tbl%0d_latency", i), lat, 3);
            chk($sformatf("tbl%0d_sum_u", i), get_sum(0), tbl[i].exp_u);
            chk($sformatf("tbl%0d_sum_s", i), get_sum(1), tbl[i].exp_s);
            chk($sformatf("tbl%0d_sum_x0", i), get_sum(2), tbl[i].exp_u);
            chk($sformatf("tbl%0d_ovf", i), ovf_m, 0);
            @(posedge clk); #1;
        end

        // Three-beat burst
        drive(1, 2, 3, 1'b1, 1'b0);
        drive(4, 5, 6, 1'b1, 1'b0);
        drive(7, 8, 9, 1'b1, 1'b1);
        collect(8);
        chk("burst_count", cnt[0], 1);
        chk("burst_sum", lsum[0], 45);
        chk("burst_ovf", lovf[0], 0);
        drive(1, 1, 1, 1'b1, 1'b1);
        collect(8);
        chk("burst_acc_cleared", lsum[0], 3);

        // Mode-0 beat inside an open burst
        drive(1, 2, 3, 1'b1, 1'b0);
        drive(10, 20, 30, 1'b0, 1'b0);
        drive(4, 5, 6, 1'b1, 1'b1);
        collect(8);
        chk("interleave_count", q_m.size(), 2);
        if (q_m.size() == 2) begin
            chk("interleave_first", q_m[0], 60);
            chk("interleave_second", q_m[1], 21);
        end

        // Accumulator overflow with no headroom bits
        drive(255, 255, 255, 1'b1, 1'b0);
        drive(255, 255, 255, 1'b1, 1'b1);
        collect(8);
        chk("x0_ovf_count", cnt[2], 1);
        chk("x0_ovf_sum", lsum[2], 506);
        chk("x0_ovf_flag", lovf[2], 1);
        chk("wide_no_ovf_sum", lsum[0], 1530);
        chk("wide_no_ovf_flag", lovf[0], 0);
        chk("signed_burst_sum", lsum[1], -6);
        drive(1, 1, 1, 1'b1, 1'b1);
        collect(8);
        chk("x0_next_sum", lsum[2], 3);
        chk("x0_next_ovf", lovf[2], 0);
        drive(255, 255, 255, 1'b1, 1'b0);
        drive(255, 255, 255, 1'b1, 1'b0);
        drive(0, 0, 0, 1'b1, 1'b1);
        collect(8);
        chk("x0_sticky_sum", lsum[2], 506);
        chk("x0_sticky_ovf", lovf[2], 1);

        // Reset with beats in flight, then with a partial accumulator
        drive(1, 2, 3, 1'b1, 1'b0);
        drive(4, 5, 6, 1'b1, 1'b1);
        do_reset();
        collect(8);
        chk("rst_inflight_burst", cnt[0], 0);
        drive(10, 20, 30, 1'b0, 1'b0);
        do_reset();
        collect(8);
        chk("rst_inflight_mode0", cnt[0], 0);
        drive(50, 50, 50, 1'b1, 1'b0);
        drive(60, 60, 60, 1'b1, 1'b0);
        collect(6);
        do_reset();
        drive(1, 1, 1, 1'b1, 1'b1);
        collect(8);
        chk("rst_acc_count", cnt[0], 1);
        chk("rst_acc_sum", lsum[0], 3);

        // Back-to-back mode-0 beats with a 4-cycle downstream stall
        do_reset();
        model_reset();
        held_prev = 1'b0;
        n_stall   = 0;
        for (int i = 0; i < 10; i++)
            step(1'b1, {8'(i), 8'(2 * i), 8'(3 * i + 1)}, 1'b0, 1'b0, !(i >= 3 && i <= 6));
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stall_in_ready_dropped", (n_stall > 0), 1);
        chk("stall_drained", exp_q.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [23:0] d;
            for (int j = 0; j < 3; j++)
                d[j*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        step(1'b1, 24'h010101, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("random_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
